// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb4.sv
// gf180mcu_fd_sc_mcu7t5v0__rrarb4
// Round-robin arbiter that shares one high-drive bus driver among N
// requesters. It issues a registered one-hot grant and inserts DEAD idle
// cycles between successive owners, so two drivers never fight on the net.
//
// Ports:
//   CLK     rising-edge clock
//   RST     synchronous active-high reset
//   REQ     per-requester level request, held until the requester is done
//   GNT     registered one-hot grant, zero when idle or in dead time
//   GNT_ID  index of the current owner, valid while BUSY=1, held otherwise
//   BUSY    registered, equals |GNT
//   VDD/VSS supply pins, carried through for cell-level compatibility
//
// Optional feature: define GF180MCU_FD_SC_MCU7T5V0_RRARB_TIMEOUT_EN to force
// release of an owner after MAX_HOLD grant cycles whenever another requester
// is waiting. Without the macro MAX_HOLD is ignored and no hold counter exists.
module gf180mcu_fd_sc_mcu7t5v0__rrarb4 #(
  parameter int N        = 4,
  parameter int DEAD     = 1,
  parameter int MAX_HOLD = 8,
  localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [N-1:0]  REQ,
  output logic [N-1:0]  GNT,
  output logic [IW-1:0] GNT_ID,
  output logic          BUSY,
  inout  wire           VDD,
  inout  wire           VSS
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [3:0]    dead;
  logic          found;
  logic [IW-1:0] win;
  logic          force_rel;
  logic          arb_now;
  logic          unused_supply;

  assign unused_supply = ^{VDD, VSS};

  // Circular search from ptr; the wrap compares against N-1 so non-power-of-2
  // N never produces an out-of-range index.
  always_comb begin
    logic [IW-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = ptr;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

  // The last dead cycle arbitrates directly, so the gap is exactly DEAD
  // zero-grant cycles.
  assign arb_now = (state == IDLE) || ((state == GAP) && (dead == 4'd1));

`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB_TIMEOUT_EN
  logic [7:0] hold;
  assign force_rel = (hold >= 8'(MAX_HOLD)) && (|(REQ & ~GNT));
`else
  assign force_rel = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      GNT    <= '0;
      GNT_ID <= '0;
      BUSY   <= 1'b0;
      ptr    <= '0;
      dead   <= '0;
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB_TIMEOUT_EN
      hold   <= '0;
`endif
    end else if (state == GRANT) begin
      if (!REQ[GNT_ID] || force_rel) begin
        GNT   <= '0;
        BUSY  <= 1'b0;
        ptr   <= (GNT_ID == IW'(N - 1)) ? '0 : GNT_ID + 1'b1;
        dead  <= 4'(DEAD);
        state <= GAP;
      end else begin
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB_TIMEOUT_EN
        if (hold != 8'hFF) hold <= hold + 1'b1;
`endif
      end
    end else if (arb_now) begin
      dead <= '0;
      if (found) begin
        GNT    <= {{(N-1){1'b0}}, 1'b1} << win;
        GNT_ID <= win;
        BUSY   <= 1'b1;
        state  <= GRANT;
`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB_TIMEOUT_EN
        hold   <= 8'd1;
`endif
      end else begin
        state <= IDLE;
      end
    end else begin
      dead <= dead - 1'b1;
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4.sv
module tb_gf180mcu_fd_sc_mcu7t5v0__rrarb4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] req_a = '0, req_b = '0;
  logic [2:0] req_c = '0;
  logic [3:0] gnt_a, gnt_b;
  logic [2:0] gnt_c;
  logic [1:0] id_a, id_b, id_c;
  logic       busy_a, busy_b, busy_c;
  wire        vdd;
  wire        vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__rrarb4 #(.N(4), .DEAD(1), .MAX_HOLD(8)) dut_a (
    .CLK(CLK), .RST(RST), .REQ(req_a), .GNT(gnt_a), .GNT_ID(id_a),
    .BUSY(busy_a), .VDD(vdd), .VSS(vss));
  gf180mcu_fd_sc_mcu7t5v0__rrarb4 #(.N(4), .DEAD(3), .MAX_HOLD(8)) dut_b (
    .CLK(CLK), .RST(RST), .REQ(req_b), .GNT(gnt_b), .GNT_ID(id_b),
    .BUSY(busy_b), .VDD(vdd), .VSS(vss));
  gf180mcu_fd_sc_mcu7t5v0__rrarb4 #(.N(3), .DEAD(2), .MAX_HOLD(8)) dut_c (
    .CLK(CLK), .RST(RST), .REQ(req_c), .GNT(gnt_c), .GNT_ID(id_c),
    .BUSY(busy_c), .VDD(vdd), .VSS(vss));

`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  // Reference model: owner index (-1 = nobody), remaining dead cycles, pointer.
  int nn[3] = '{4, 4, 3};
  int dd[3] = '{1, 3, 2};
  int m_owner[3], m_gap[3], m_ptr[3], m_hold[3], m_id[3];

  task automatic model_step(input int i, input logic [7:0] req, input logic rst);
    if (rst) begin
      m_owner[i] = -1; m_gap[i] = 0; m_ptr[i] = 0; m_hold[i] = 0; m_id[i] = 0;
    end else if (m_owner[i] >= 0) begin
      bit others = 0;
      for (int j = 0; j < nn[i]; j++)
        if (j != m_owner[i] && req[j]) others = 1;
      if (!req[m_owner[i]] || (TIMEOUT && m_hold[i] >= 8 && others)) begin
        m_ptr[i]   = (m_owner[i] + 1) % nn[i];
        m_owner[i] = -1;
        m_gap[i]   = dd[i];
      end else if (m_hold[i] < 255) begin
        m_hold[i]++;
      end
    end else if (m_gap[i] > 1) begin
      m_gap[i]--;
    end else begin
      m_gap[i] = 0;
      for (int k = 0; k < nn[i]; k++) begin
        int c = (m_ptr[i] + k) % nn[i];
        if (m_owner[i] < 0 && req[c]) begin
          m_owner[i] = c; m_id[i] = c; m_hold[i] = 1;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i);
    int g, id, b;
    int eg;
    case (i)
      0: begin g = int'(gnt_a); id = int'(id_a); b = int'(busy_a); end
      1: begin g = int'(gnt_b); id = int'(id_b); b = int'(busy_b); end
      default: begin g = int'(gnt_c); id = int'(id_c); b = int'(busy_c); end
    endcase
    eg = (m_owner[i] >= 0) ? (1 << m_owner[i]) : 0;
    check($sformatf("model%0d.gnt", i), g, eg);
    check($sformatf("model%0d.id", i), id, m_id[i]);
    check($sformatf("model%0d.busy", i), b, (m_owner[i] >= 0) ? 1 : 0);
    check($sformatf("model%0d.onehot", i), ($countones(g) <= 1) ? 1 : 0, 1);
  endtask

  task automatic cycle(input logic rst, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [2:0] rc);
    RST = rst; req_a = ra; req_b = rb; req_c = rc;
    @(posedge CLK);
    model_step(0, {4'b0, ra}, rst);
    model_step(1, {4'b0, rb}, rst);
    model_step(2, {5'b0, rc}, rst);
    #1;
    for (int i = 0; i < 3; i++) check_inst(i);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t vec[19];

  initial begin
    logic [3:0] ra, rb;
    logic [2:0] rc;
    logic [3:0] exp5;
    // Rotation on the N=4, DEAD=1 instance with reset at the start.
    vec[0]  = '{1'b1, 4'hF, 4'h0, 2'd0, 1'b0};
    vec[1]  = '{1'b1, 4'hF, 4'h0, 2'd0, 1'b0};
    vec[2]  = '{1'b0, 4'hF, 4'h1, 2'd0, 1'b1};
    vec[3]  = '{1'b0, 4'hF, 4'h1, 2'd0, 1'b1};
    vec[4]  = '{1'b0, 4'hF, 4'h1, 2'd0, 1'b1};
    vec[5]  = '{1'b0, 4'hE, 4'h0, 2'd0, 1'b0};
    vec[6]  = '{1'b0, 4'hF, 4'h2, 2'd1, 1'b1};
    vec[7]  = '{1'b0, 4'hF, 4'h2, 2'd1, 1'b1};
    vec[8]  = '{1'b0, 4'hF, 4'h2, 2'd1, 1'b1};
    vec[9]  = '{1'b0, 4'hD, 4'h0, 2'd1, 1'b0};
    vec[10] = '{1'b0, 4'hF, 4'h4, 2'd2, 1'b1};
    vec[11] = '{1'b0, 4'hF, 4'h4, 2'd2, 1'b1};
    vec[12] = '{1'b0, 4'hF, 4'h4, 2'd2, 1'b1};
    vec[13] = '{1'b0, 4'hB, 4'h0, 2'd2, 1'b0};
    vec[14] = '{1'b0, 4'hF, 4'h8, 2'd3, 1'b1};
    vec[15] = '{1'b0, 4'hF, 4'h8, 2'd3, 1'b1};
    vec[16] = '{1'b0, 4'hF, 4'h8, 2'd3, 1'b1};
    vec[17] = '{1'b0, 4'h7, 4'h0, 2'd3, 1'b0};
    vec[18] = '{1'b0, 4'hF, 4'h1, 2'd0, 1'b1};

    for (int i = 0; i < 3; i++) model_step(i, 8'h0, 1'b1);
    #2;

    for (int v = 0; v < 19; v++) begin
      cycle(vec[v].rst, vec[v].req, vec[v].req, vec[v].req[2:0]);
      check($sformatf("vec%0d.gnt", v), int'(gnt_a), int'(vec[v].gnt));
      check($sformatf("vec%0d.id", v), int'(id_a), int'(vec[v].id));
      check($sformatf("vec%0d.busy", v), int'(busy_a), int'(vec[v].busy));
    end

    // Owner 2 releases as 3 and 0 request; DEAD=3 gap, then 3 wins.
    cycle(1'b1, 4'h0, 4'h0, 3'h0);
    cycle(1'b0, 4'h0, 4'h4, 3'h0);
    check("gap3.grant2", int'(gnt_b), 4);
    cycle(1'b0, 4'h0, 4'h4, 3'h0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 4'h0, 4'h9, 3'h0);
      check($sformatf("gap3.zero%0d", k), int'(gnt_b), 0);
    end
    cycle(1'b0, 4'h0, 4'h9, 3'h0);
    check("gap3.grant3", int'(gnt_b), 8);
    check("gap3.id3", int'(id_b), 3);

    // Reset in the middle of a grant; pointer returns to 0.
    cycle(1'b0, 4'h4, 4'h0, 3'h0);
    cycle(1'b0, 4'h4, 4'h0, 3'h0);
    check("midrst.pre", int'(gnt_a), 4);
    cycle(1'b1, 4'h4, 4'h0, 3'h0);
    check("midrst.gnt", int'(gnt_a), 0);
    check("midrst.busy", int'(busy_a), 0);
    cycle(1'b0, 4'h4, 4'h0, 3'h0);
    check("midrst.regrant", int'(gnt_a), 4);

    // Hold limit with two steady requesters.
    cycle(1'b1, 4'h0, 4'h0, 3'h0);
    for (int k = 0; k < 19; k++) begin
      cycle(1'b0, 4'h3, 4'h0, 3'h0);
      if (!TIMEOUT)      exp5 = 4'h1;
      else if (k < 8)    exp5 = 4'h1;
      else if (k == 8)   exp5 = 4'h0;
      else if (k < 17)   exp5 = 4'h2;
      else if (k == 17)  exp5 = 4'h0;
      else               exp5 = 4'h1;
      check($sformatf("hold.k%0d", k), int'(gnt_a), int'(exp5));
    end

    // N=3 rotation with wrap from 2 back to 0, DEAD=2.
    cycle(1'b1, 4'h0, 4'h0, 3'h0);
    cycle(1'b0, 4'h0, 4'h0, 3'h7);
    check("n3.g0", int'(gnt_c), 1);
    cycle(1'b0, 4'h0, 4'h0, 3'h6);
    cycle(1'b0, 4'h0, 4'h0, 3'h7);
    check("n3.gap", int'(gnt_c), 0);
    cycle(1'b0, 4'h0, 4'h0, 3'h7);
    check("n3.g1", int'(gnt_c), 2);
    cycle(1'b0, 4'h0, 4'h0, 3'h5);
    cycle(1'b0, 4'h0, 4'h0, 3'h7);
    cycle(1'b0, 4'h0, 4'h0, 3'h7);
    check("n3.g2", int'(gnt_c), 4);
    check("n3.id2", int'(id_c), 2);
    cycle(1'b0, 4'h0, 4'h0, 3'h3);
    cycle(1'b0, 4'h0, 4'h0, 3'h7);
    cycle(1'b0, 4'h0, 4'h0, 3'h7);
    check("n3.wrap0", int'(gnt_c), 1);
    check("n3.id0", int'(id_c), 0);

    // Random traffic against the model.
    ra = '0; rb = '0; rc = '0;
    for (int k = 0; k < 600; k++) begin
      ra ^= 4'($urandom & $urandom);
      rb ^= 4'($urandom & $urandom);
      rc ^= 3'($urandom & $urandom);
      cycle(($urandom_range(63) == 0), ra, rb, rc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
